// File: rtl/adc_capture_ctrl_pkg.sv
// Shared types and constants for the ADC capture controller slice.
package adc_cap_pkg;

    localparam int unsigned DEPTH_LOG2_DEF = 10;

    localparam logic EDGE_RISE   = 1'b0;
    localparam logic EDGE_FALL   = 1'b1;
    localparam logic MODE_CONT   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ARMED,
        ST_POST,
        ST_HOLD
    } cap_state_e;

    function automatic logic in_capture(cap_state_e s);
        return s inside {ST_PRE, ST_ARMED, ST_POST};
    endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Sample stream, UI configuration, frame-buffer write port and status of adc_capture_ctrl.
interface adc_capture_ctrl_if
    import adc_cap_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
);
    logic                  smp_valid;
    logic [7:0]            smp_data;
    logic [7:0]            cfg_decim;
    logic [7:0]            cfg_trig_level;
    logic                  cfg_trig_edge;
    logic [DEPTH_LOG2-1:0] cfg_pre_len;
    logic                  cfg_mode;
    logic                  arm;
    logic                  frame_ack;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [7:0]            wr_data;
    logic [DEPTH_LOG2-1:0] frame_start;
    logic                  frame_rdy;
    logic                  busy;
    logic                  trig_seen;

    modport master (
        output smp_valid, smp_data, cfg_decim, cfg_trig_level, cfg_trig_edge,
               cfg_pre_len, cfg_mode, arm, frame_ack,
        input  wr_en, wr_addr, wr_data, frame_start, frame_rdy, busy, trig_seen
    );

    modport slave (
        input  smp_valid, smp_data, cfg_decim, cfg_trig_level, cfg_trig_edge,
               cfg_pre_len, cfg_mode, arm, frame_ack,
        output wr_en, wr_addr, wr_data, frame_start, frame_rdy, busy, trig_seen
    );
endinterface

// File: rtl/adc_capture_ctrl_trig.sv
// Level-crossing trigger detector: tracks the previous accepted sample and
// flags a rising/falling crossing on the current accepted sample.
module adc_trig_detect
    import adc_cap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       accept,
    input  logic [7:0] sample,
    input  logic [7:0] level,
    input  logic       edge_sel,
    output logic       trig
);
    logic [7:0] prev_q, prev_d;
    logic       prev_vld_q, prev_vld_d;
    logic       prev_below, cur_below;

    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        if (clr) begin
            prev_vld_d = 1'b0;
        end else if (accept) begin
            prev_d     = sample;
            prev_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    assign prev_below = (prev_q < level);
    assign cur_below  = (sample < level);

    always_comb begin
        trig = 1'b0;
        if (accept && prev_vld_q) begin
            if (edge_sel == EDGE_RISE) trig = prev_below && !cur_below;
            else                       trig = !prev_below && cur_below;
        end
    end
endmodule

// File: rtl/adc_capture_ctrl.sv
// Decimating pre/post-trigger capture sequencer for the waveform frame buffer.
// Optional auto-trigger timeout is compiled in with `define TRIG_TIMEOUT_EN.
module adc_capture_ctrl
    import adc_cap_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF,
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    adc_capture_ctrl_if.slave bus
);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    if (TIMEOUT_CYC == 0) begin : g_timeout_chk
        $error("TIMEOUT_CYC must be non-zero");
    end

    cap_state_e            state_q, state_d;
    logic [7:0]            decim_q, decim_d;
    logic [7:0]            level_q, level_d;
    logic                  edge_q, edge_d;
    logic [DEPTH_LOG2-1:0] pre_len_q, pre_len_d;
    logic                  mode_q, mode_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [7:0]            dcnt_q, dcnt_d;
    logic [DEPTH_LOG2-1:0] pre_cnt_q, pre_cnt_d;
    logic [DEPTH_LOG2-1:0] rem_q, rem_d;
    logic [DEPTH_LOG2-1:0] frame_start_q, frame_start_d;
    logic                  frame_rdy_q, frame_rdy_d;
    logic                  trig_seen_q, trig_seen_d;
    logic                  last_q, last_d;
    logic                  wr_en_q, wr_en_d;
    logic [DEPTH_LOG2-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;

    logic capturing, accept, trig_hit, timeout, start_pre;

    assign capturing = in_capture(state_q);
    assign accept    = capturing && bus.smp_valid && (dcnt_q == '0);

    adc_trig_detect u_trig (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .clr      (start_pre),
        .accept   (accept),
        .sample   (bus.smp_data),
        .level    (level_q),
        .edge_sel (edge_q),
        .trig     (trig_hit)
    );

`ifdef TRIG_TIMEOUT_EN
    logic [31:0] tcnt_q, tcnt_d;

    assign timeout = (tcnt_q >= TIMEOUT_CYC);

    always_comb begin
        tcnt_d = '0;
        if (state_q == ST_ARMED) tcnt_d = timeout ? tcnt_q : tcnt_q + 32'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) tcnt_q <= '0;
        else            tcnt_q <= tcnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        decim_d       = decim_q;
        level_d       = level_q;
        edge_d        = edge_q;
        pre_len_d     = pre_len_q;
        mode_d        = mode_q;
        ptr_d         = ptr_q;
        dcnt_d        = dcnt_q;
        pre_cnt_d     = pre_cnt_q;
        rem_d         = rem_q;
        frame_start_d = frame_start_q;
        frame_rdy_d   = frame_rdy_q;
        trig_seen_d   = trig_seen_q;
        last_d        = 1'b0;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        start_pre     = 1'b0;

        if (capturing && bus.smp_valid) begin
            dcnt_d = (dcnt_q == '0) ? decim_q : dcnt_q - 8'd1;
        end

        if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = bus.smp_data;
            ptr_d     = ptr_q + PTR_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.arm) start_pre = 1'b1;
            end
            ST_PRE: begin
                if (accept) pre_cnt_d = pre_cnt_q + PTR_ONE;
                if ((pre_len_q == '0) || (accept && (pre_cnt_q + PTR_ONE) == pre_len_q)) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (accept && (trig_hit || timeout)) begin
                    frame_start_d = ptr_q - pre_len_q;
                    trig_seen_d   = trig_hit;
                    // ~pre_len == 2^N - pre_len - 1 in N bits
                    rem_d         = ~pre_len_q;
                    if (pre_len_q == '1) begin
                        state_d = ST_HOLD;
                        last_d  = 1'b1;
                    end else begin
                        state_d = ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (accept) begin
                    rem_d = rem_q - PTR_ONE;
                    if (rem_q == PTR_ONE) begin
                        state_d = ST_HOLD;
                        last_d  = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.frame_ack && frame_rdy_q) begin
                    frame_rdy_d = 1'b0;
                    if (mode_q == MODE_CONT) start_pre = 1'b1;
                    else                     state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // last_q trails the final accept so frame_rdy follows the visible write pulse
        if (last_q) frame_rdy_d = 1'b1;

        if (start_pre) begin
            state_d   = ST_PRE;
            decim_d   = bus.cfg_decim;
            level_d   = bus.cfg_trig_level;
            edge_d    = bus.cfg_trig_edge;
            pre_len_d = bus.cfg_pre_len;
            mode_d    = bus.cfg_mode;
            ptr_d     = '0;
            dcnt_d    = '0;
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            decim_q       <= '0;
            level_q       <= '0;
            edge_q        <= EDGE_RISE;
            pre_len_q     <= '0;
            mode_q        <= MODE_CONT;
            ptr_q         <= '0;
            dcnt_q        <= '0;
            pre_cnt_q     <= '0;
            rem_q         <= '0;
            frame_start_q <= '0;
            frame_rdy_q   <= 1'b0;
            trig_seen_q   <= 1'b0;
            last_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            decim_q       <= decim_d;
            level_q       <= level_d;
            edge_q        <= edge_d;
            pre_len_q     <= pre_len_d;
            mode_q        <= mode_d;
            ptr_q         <= ptr_d;
            dcnt_q        <= dcnt_d;
            pre_cnt_q     <= pre_cnt_d;
            rem_q         <= rem_d;
            frame_start_q <= frame_start_d;
            frame_rdy_q   <= frame_rdy_d;
            trig_seen_q   <= trig_seen_d;
            last_q        <= last_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_rdy   = frame_rdy_q;
    assign bus.busy        = capturing;
    assign bus.trig_seen   = trig_seen_q;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a 16-entry frame buffer.
module tb_adc_capture_ctrl;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];
    int         rdy_cyc = -1;
    logic       rdy_prev = 1'b0;
    int         rdy_hi;

    adc_capture_ctrl_if #(.DEPTH_LOG2(4)) bus ();

    adc_capture_ctrl #(.DEPTH_LOG2(4), .TIMEOUT_CYC(100)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (bus.wr_en === 1'b1) begin
            wa.push_back(bus.wr_addr);
            wd.push_back(bus.wr_data);
            wc.push_back(cyc);
        end
        if (bus.frame_rdy === 1'b1 && !rdy_prev) rdy_cyc = cyc;
        rdy_prev = (bus.frame_rdy === 1'b1);
    end

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        rdy_cyc = -1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] decim, input logic [7:0] lvl, input logic edg,
                           input logic [3:0] pre, input logic mode);
        bus.cfg_decim      = decim;
        bus.cfg_trig_level = lvl;
        bus.cfg_trig_edge  = edg;
        bus.cfg_pre_len    = pre;
        bus.cfg_mode       = mode;
    endtask

    initial begin
        bus.smp_valid = 1'b0;
        bus.smp_data  = '0;
        bus.arm       = 1'b0;
        bus.frame_ack = 1'b0;
        set_cfg(8'd0, 8'h80, 1'b0, 4'd4, 1'b1);
        repeat (3) step();

        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_frame_start", bus.frame_start, 0);
        check("rst_frame_rdy", bus.frame_rdy, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_trig_seen", bus.trig_seen, 0);
        sys_rst_n = 1'b1;
        step();

        // Ramp, pre_len=4, rising at 0x80, single mode
        clear_log();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        check("t1_busy_after_arm", bus.busy, 1);
        bus.cfg_pre_len = 4'd7;
        for (int k = 0; k < 30; k++) begin
            bus.smp_valid = 1'b1;
            bus.smp_data  = 8'(k * 16);
            step();
        end
        bus.smp_valid = 1'b0;
        step();
        check("t1_write_count", wa.size(), 20);
        for (int i = 0; i < 4; i++) check("t1_pre_addr", wa[i], i);
        check("t1_pre_data3", wd[3], 8'h30);
        check("t1_trig_addr", wa[8], 8);
        check("t1_trig_data", wd[8], 8'h80);
        check("t1_last_addr", wa[19], 3);
        check("t1_frame_start", bus.frame_start, 4);
        check("t1_frame_rdy", bus.frame_rdy, 1);
        check("t1_busy_hold", bus.busy, 0);
        check("t1_trig_seen", bus.trig_seen, 1);
        check("t1_rdy_latency", rdy_cyc - wc[19], 1);

        // Single mode: ack returns to IDLE, no writes until arm
        bus.frame_ack = 1'b1;
        step();
        bus.frame_ack = 1'b0;
        check("t1_rdy_after_ack", bus.frame_rdy, 0);
        check("t1_busy_after_ack", bus.busy, 0);
        clear_log();
        for (int k = 0; k < 5; k++) begin
            bus.smp_valid = 1'b1;
            bus.smp_data  = 8'hFF;
            step();
        end
        bus.smp_valid = 1'b0;
        step();
        check("t1_idle_no_writes", wa.size(), 0);
        check("t1_idle_busy", bus.busy, 0);

        // Decimation by 3, continuous mode
        set_cfg(8'd2, 8'h80, 1'b0, 4'd2, 1'b0);
        clear_log();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        for (int n = 0; n < 100; n++) begin
            bus.smp_valid = 1'b1;
            bus.smp_data  = 8'(n * 8);
            step();
            if (bus.frame_rdy === 1'b1) break;
        end
        bus.smp_valid = 1'b0;
        check("t2_frame_rdy", bus.frame_rdy, 1);
        check("t2_write_count", wa.size(), 20);
        check("t2_gap01", wc[1] - wc[0], 3);
        check("t2_gap12", wc[2] - wc[1], 3);
        for (int i = 0; i < 7; i++) check("t2_addr_seq", wa[i], i);
        check("t2_trig_data", wd[6], 8'h90);
        check("t2_frame_start", bus.frame_start, 4);

        // Continuous: ack with simultaneous arm restarts PRE from address 0
        bus.frame_ack = 1'b1;
        bus.arm = 1'b1;
        step();
        bus.frame_ack = 1'b0;
        bus.arm = 1'b0;
        check("t2_busy_after_ack", bus.busy, 1);
        check("t2_rdy_after_ack", bus.frame_rdy, 0);
        clear_log();
        bus.smp_valid = 1'b1;
        bus.smp_data  = 8'hAA;
        step();
        bus.smp_valid = 1'b0;
        step();
        check("t2_restart_count", wa.size(), 1);
        check("t2_restart_addr", wa[0], 0);
        check("t2_restart_data", wd[0], 8'hAA);

        // Falling edge at 0x40, then reset while in POST
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        set_cfg(8'd0, 8'h40, 1'b1, 4'd1, 1'b1);
        step();
        clear_log();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.smp_valid = 1'b1;
            case (k)
                0: bus.smp_data = 8'h50;
                1: bus.smp_data = 8'h40;
                2: bus.smp_data = 8'h3F;
                default: bus.smp_data = 8'h10;
            endcase
            step();
        end
        check("t3_frame_start", bus.frame_start, 1);
        check("t3_trig_data", wd[2], 8'h3F);
        check("t3_busy_post", bus.busy, 1);
        check("t3_trig_seen", bus.trig_seen, 1);
        check("t3_wr_en_pre_rst", bus.wr_en, 1);
        check("t3_writes_pre_rst", wa.size(), 4);
        #1 sys_rst_n = 1'b0;
        #1;
        check("t4_rst_wr_en", bus.wr_en, 0);
        check("t4_rst_wr_addr", bus.wr_addr, 0);
        check("t4_rst_wr_data", bus.wr_data, 0);
        check("t4_rst_frame_start", bus.frame_start, 0);
        check("t4_rst_busy", bus.busy, 0);
        check("t4_rst_trig_seen", bus.trig_seen, 0);
        check("t4_rst_frame_rdy", bus.frame_rdy, 0);
        repeat (5) step();
        check("t4_no_writes_in_rst", wa.size(), 4);
        sys_rst_n = 1'b1;
        bus.smp_valid = 1'b0;
        step();

        // pre_len = 15: trigger completes the frame directly
        set_cfg(8'd0, 8'h80, 1'b0, 4'd15, 1'b1);
        clear_log();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        check("t5_busy_after_arm", bus.busy, 1);
        for (int k = 0; k < 19; k++) begin
            bus.smp_valid = 1'b1;
            bus.smp_data  = (k == 15) ? 8'h90 : 8'h00;
            step();
        end
        bus.smp_valid = 1'b0;
        step();
        check("t5_write_count", wa.size(), 16);
        check("t5_first_addr", wa[0], 0);
        check("t5_trig_addr", wa[15], 15);
        check("t5_trig_data", wd[15], 8'h90);
        check("t5_frame_start", bus.frame_start, 0);
        check("t5_frame_rdy", bus.frame_rdy, 1);
        check("t5_rdy_latency", rdy_cyc - wc[15], 1);
        bus.frame_ack = 1'b1;
        step();
        bus.frame_ack = 1'b0;
        step();

        // Constant input never crosses the level
        set_cfg(8'd0, 8'h80, 1'b0, 4'd4, 1'b1);
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        bus.smp_valid = 1'b1;
        bus.smp_data  = 8'h20;
        rdy_hi = 0;
`ifdef TRIG_TIMEOUT_EN
        for (int k = 0; k < 1000; k++) begin
            step();
            if (bus.frame_rdy === 1'b1) break;
        end
        check("t6_timeout_rdy", bus.frame_rdy, 1);
        check("t6_timeout_trig_seen", bus.trig_seen, 0);
`else
        for (int k = 0; k < 10000; k++) begin
            step();
            if (bus.frame_rdy !== 1'b0) rdy_hi++;
        end
        check("t6_no_rdy", rdy_hi, 0);
        check("t6_still_busy", bus.busy, 1);
`endif
        bus.smp_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
